gf180mcu_fd_sc_mcu9t5v0_tiebank: RTL
====================================

Name: gf180mcu_fd_sc_mcu9t5v0_tiebank

Overview:
- Parametrised successor to the single-bit tie-low cell: a WIDTH-bit bank of registered tie-off outputs.
- Z comes out of reset at a fixed RESET_VAL; all-zeros is equivalent to WIDTH tie-low cells.
- Z can be reprogrammed through a serial shift / shadow / commit path, and can be locked until the next reset.
- Used for post-silicon strap and trim values on block boundaries, where a hard tie cell would be too rigid.

Parameters:
- WIDTH, 8, number of tie outputs. Legal range 1..64.
- RESET_VAL, {WIDTH{1'b0}}, value driven on Z and loaded into the shadow register during reset.
- LOCK_EN, 1, when 0 the LOCK input is ignored and LOCKED stays 0.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- SE  input  1  shift enable. While high, shadow shifts one bit per cycle.
- SI  input  1  serial data in. Enters at shadow MSB.
- SO  output  1  serial data out, equal to shadow[0]. Used for chaining banks.
- UPD  input  1  commit request, single-cycle strobe.
- LOCK  input  1  lock request.
- Z  output  WIDTH  registered tie-off values.
- LOCKED  output  1  bank is locked.
- ERR  output  1  sticky commit-error flag.
- VDD  inout  1  supply.
- VSS  inout  1  ground.

Behaviour:
- Reset (RST high at a rising edge):
  - Z = RESET_VAL, shadow = RESET_VAL, SO = RESET_VAL[0].
  - cnt = 0, state = IDLE, LOCKED = 0, ERR = 0.
  - RST has priority over every other input. Asserting RST mid-shift discards the partial load.
- Counter: cnt is $clog2(WIDTH+2) bits wide and saturates at WIDTH+1, which flags an overrun.
- States and transitions:
  - IDLE -> SHIFT when SE=1.
  - SHIFT, each SE=1 cycle: shadow <= {SI, shadow[WIDTH-1:1]} and cnt increments (saturating).
  - SHIFT, SE=0: state holds, and the shadow and cnt values are retained.
  - IDLE or SHIFT with UPD=1:
    - If cnt==WIDTH: Z <= shadow, ERR <= 0, cnt <= 0, state -> IDLE.
    - Otherwise: Z unchanged, ERR <= 1, cnt <= 0, shadow <= Z (re-synced), state -> IDLE.
  - Any state except LOCKED with LOCK=1, LOCK_EN=1, SE=0 and UPD=0: state -> LOCKED and LOCKED <= 1, both at the same edge.
  - LOCKED: SE, UPD and LOCK are ignored. Z and shadow are frozen and SO holds. The only exit is RST.
- Simultaneous inputs, priority: RST > UPD > SE > LOCK.
  - UPD together with SE: the commit uses the pre-shift shadow and cnt, and no shift occurs.
  - LOCK together with SE or UPD: LOCK is dropped and must be re-requested.
- Latency:
  - UPD sampled at edge n updates Z at edge n; the new value is visible in cycle n+1.
  - SO changes one edge after each shift.
  - Z changes only on reset or on an accepted commit, so it never glitches during shifting.
- Width rules:
  - WIDTH=1 is legal: a single shift followed by UPD commits.
  - RESET_VAL must be exactly WIDTH bits; an elaboration check enforces this.

Decomposition:
- Shared package gf180mcu_fd_sc_mcu9t5v0_tiebank_pkg, containing:
  - the state enum (IDLE, SHIFT, LOCKED);
  - the counter-width function;
  - the priority encoding constants.
- Sub-module gf180mcu_fd_sc_mcu9t5v0_tiebank_shreg holds the shadow shift register with load-from-Z and SO. Control logic and the FSM stay in the top.

Test Plan:
- Reset: RST=1 for 2 cycles with WIDTH=8 and RESET_VAL=8'h00 -> Z=8'h00, SO=0, LOCKED=0, ERR=0. Behaviour matches tie-low on all bits.
- Good commit: shift SI = 1,0,1,1,0,0,1,0 (8 cycles), then UPD -> Z=8'h4D one cycle after UPD, ERR=0, and Z is stable during the shift.
- Short load: 5 shifts then UPD -> Z unchanged, ERR=1, shadow reloaded from Z (SO=Z[0]). A following full 8-bit load of 8'hA5 plus UPD -> Z=8'hA5 and ERR=0.
- Overrun: 9 shifts then UPD -> cnt saturates at 9, commit rejected, ERR=1.
- Lock: commit 8'h3C, then LOCK -> LOCKED=1. Afterwards a full 8-bit shift of 8'hFF plus UPD leaves Z=8'h3C and SO frozen. RST -> Z=8'h00, LOCKED=0.
- Collisions:
  - SE+UPD in the same cycle after a full 8-bit load -> the commit uses the pre-shift shadow and no shift occurs.
  - LOCK+SE in the same cycle -> LOCKED stays 0.
  - RST asserted mid-shift after 4 bits -> full reset values.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_tiebank_pkg.sv
// Shared types and helpers for the programmable tie-off bank.
package gf180mcu_fd_sc_mcu9t5v0_tiebank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Resolved action per cycle; numeric order mirrors input priority UPD > SE > LOCK.
    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_LOCK   = 2'd1,
        ACT_SHIFT  = 2'd2,
        ACT_COMMIT = 2'd3
    } act_e;

    localparam int PRI_RST  = 3;
    localparam int PRI_UPD  = 2;
    localparam int PRI_SE   = 1;
    localparam int PRI_LOCK = 0;

    // Counter must reach WIDTH+1 so an overrun is distinguishable from a full load.
    function automatic int cnt_w(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_tiebank_shreg.sv
// Shadow shift register: serial load LSB-first from SI at the MSB, parallel re-sync from Z.
module gf180mcu_fd_sc_mcu9t5v0_tiebank_shreg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             si,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] shadow,
    output logic             so
);

    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted = si;
        end else begin : g_wn
            assign shifted = {si, shadow[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            shadow <= RST_VAL;
        else if (load_en)
            shadow <= load_val;
        else if (shift_en)
            shadow <= shifted;
    end

    assign so = shadow[0];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_tiebank.sv
// WIDTH-bit registered tie-off bank, reprogrammable via shift/shadow/commit and lockable until reset.
module gf180mcu_fd_sc_mcu9t5v0_tiebank
    import gf180mcu_fd_sc_mcu9t5v0_tiebank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter     RESET_VAL = {WIDTH{1'b0}},
    parameter bit LOCK_EN   = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
    input  logic             UPD,
    input  logic             LOCK,
    output logic [WIDTH-1:0] Z,
    output logic             LOCKED,
    output logic             ERR,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int               CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_SAT  = CW'(WIDTH + 1);
    localparam logic [WIDTH-1:0] RST_V    = RESET_VAL;

    generate
        if ($bits(RESET_VAL) != WIDTH) begin : g_bad_reset_val
            $error("RESET_VAL must be exactly WIDTH bits");
        end
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("WIDTH must be in 1..64");
        end
    endgenerate

    // Supply pins are pass-through for the netlist; no logic depends on them.
    logic unused_pwr;
    assign unused_pwr = VDD ^ VSS;

    state_e           state;
    act_e             act;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shadow;
    logic             commit_ok;

    always_comb begin
        act = ACT_NONE;
        if (state != ST_LOCKED) begin
            if (UPD)
                act = ACT_COMMIT;
            else if (SE)
                act = ACT_SHIFT;
            else if (LOCK && LOCK_EN)
                act = ACT_LOCK;
        end
    end

    assign commit_ok = (cnt == CNT_FULL);

    gf180mcu_fd_sc_mcu9t5v0_tiebank_shreg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_V)
    ) u_shreg (
        .clk      (CLK),
        .rst      (RST),
        .shift_en (act == ACT_SHIFT),
        .si       (SI),
        .load_en  (act == ACT_COMMIT && !commit_ok),
        .load_val (Z),
        .shadow   (shadow),
        .so       (SO)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            Z      <= RST_V;
            cnt    <= '0;
            state  <= ST_IDLE;
            LOCKED <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            case (act)
                ACT_COMMIT: begin
                    if (commit_ok) begin
                        Z   <= shadow;
                        ERR <= 1'b0;
                    end else begin
                        ERR <= 1'b1;
                    end
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                ACT_SHIFT: begin
                    if (cnt != CNT_SAT)
                        cnt <= cnt + 1'b1;
                    state <= ST_SHIFT;
                end
                ACT_LOCK: begin
                    state  <= ST_LOCKED;
                    LOCKED <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
